// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding, address width and the OLED address
// that both the master and this target agree on.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam logic [I2C_ADDR_W-1:0] OLED_ADDRESS = 7'h3C;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_IGNORE    = 3'd7
    } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw SCL/SDA pins and derives SCL edges and START/STOP.
// A START/STOP is only reported when SCL was high on both sampled cycles, so an
// SDA change landing in the same sampled cycle as an SCL change counts as data.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_p;
    logic                   r_sda_p;
    logic                   w_scl_s;
    logic                   w_sda_s;

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    // Synchronizer chains plus one delayed copy; reset to the idle-bus level.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_p    <= 1'b1;
            r_sda_p    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_p    <= w_scl_s;
            r_sda_p    <= w_sda_s;
        end
    end

    assign o_scl_rise  = w_scl_s & ~r_scl_p;
    assign o_scl_fall  = ~w_scl_s & r_scl_p;
    assign o_start_det = w_scl_s & r_scl_p & r_sda_p & ~w_sda_s;
    assign o_stop_det  = w_scl_s & r_scl_p & ~r_sda_p & w_sda_s;
    assign o_sda_s     = w_sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, ACK generation, write-byte delivery and read-byte
// serving from a user port. No clock stretching; SDA only changes after an SCL
// fall, or when released on START/STOP/reset.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | bus free, waiting for START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for a matched address
// ST_WRITE     | shifting in a data byte from the master
// ST_WRITE_ACK | driving ACK for a received byte
// ST_READ      | driving a data byte to the master
// ST_READ_ACK  | sampling master ACK/NACK
// ST_IGNORE    | not ours or read finished, waiting for START/STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDRESS     = OLED_ADDRESS,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_drive_low,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_load,
    output logic       o_busy,
    output logic       o_addressed
);

    logic       w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

    i2c_state_t r_state, w_state;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic       r_ninth, w_ninth;
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_tx, w_tx;
    logic       r_sda_low, w_sda_low;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_tx_load, w_tx_load;
    logic       r_busy, w_busy;
    logic       r_addressed, w_addressed;
    logic       r_ack_bit, w_ack_bit;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_scl       (i_scl),
        .i_sda       (i_sda),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start_det),
        .o_stop_det  (w_stop_det),
        .o_sda_s     (w_sda_s)
    );

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_ninth     <= 1'b0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_sda_low   <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_load   <= 1'b0;
            r_busy      <= 1'b0;
            r_addressed <= 1'b0;
            r_ack_bit   <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_bit_cnt   <= w_bit_cnt;
            r_ninth     <= w_ninth;
            r_shift     <= w_shift;
            r_tx        <= w_tx;
            r_sda_low   <= w_sda_low;
            r_rx_data   <= w_rx_data;
            r_rx_valid  <= w_rx_valid;
            r_tx_load   <= w_tx_load;
            r_busy      <= w_busy;
            r_addressed <= w_addressed;
            r_ack_bit   <= w_ack_bit;
        end
    end

    // Next-state logic; STOP beats START beats per-state bit handling.
    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_ninth     = r_ninth;
        w_shift     = r_shift;
        w_tx        = r_tx;
        w_sda_low   = r_sda_low;
        w_rx_data   = r_rx_data;
        w_rx_valid  = 1'b0;
        w_tx_load   = 1'b0;
        w_busy      = r_busy;
        w_addressed = r_addressed;
        w_ack_bit   = r_ack_bit;

        if (w_stop_det) begin
            w_state     = ST_IDLE;
            w_sda_low   = 1'b0;
            w_busy      = 1'b0;
            w_addressed = 1'b0;
        end else if (w_start_det) begin
            w_state     = ST_ADDR;
            w_bit_cnt   = 3'd0;
            w_ninth     = 1'b0;
            w_sda_low   = 1'b0;
            w_busy      = 1'b1;
            w_addressed = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_WRITE: begin
                    // The counter wraps 7->0 on the 8th rise; r_ninth marks the ACK slot.
                    if (w_scl_rise && !r_ninth) begin
                        w_shift   = {r_shift[6:0], w_sda_s};
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_ninth = 1'b1;
                            if (r_state == ST_WRITE) begin
                                w_rx_data  = {r_shift[6:0], w_sda_s};
                                w_rx_valid = 1'b1;
                            end
                        end
                    end else if (w_scl_fall && r_ninth) begin
                        w_ninth = 1'b0;
                        if (r_state == ST_WRITE) begin
                            w_sda_low = 1'b1;
                            w_state   = ST_WRITE_ACK;
                        end else if (r_shift[7:1] == ADDRESS) begin
                            w_sda_low = 1'b1;
                            w_state   = ST_ADDR_ACK;
                        end else begin
                            w_state = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_addressed = 1'b1;
                        w_bit_cnt   = 3'd0;
                        if (r_shift[0]) begin
                            w_tx      = i_tx_data;
                            w_tx_load = 1'b1;
                            w_sda_low = ~i_tx_data[7];
                            w_state   = ST_READ;
                        end else begin
                            w_sda_low = 1'b0;
                            w_state   = ST_WRITE;
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low = 1'b0;
                        w_bit_cnt = 3'd0;
                        w_state   = ST_WRITE;
                    end
                end
                ST_READ: begin
                    // Bit 7 is already on the line; each fall presents the next one.
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_sda_low = 1'b0;
                            w_bit_cnt = 3'd0;
                            w_state   = ST_READ_ACK;
                        end else begin
                            w_tx      = {r_tx[6:0], 1'b0};
                            w_sda_low = ~r_tx[6];
                            w_bit_cnt = r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_bit = w_sda_s;
                    end else if (w_scl_fall) begin
                        if (!r_ack_bit) begin
                            w_tx      = i_tx_data;
                            w_tx_load = 1'b1;
                            w_sda_low = ~i_tx_data[7];
                            w_bit_cnt = 3'd0;
                            w_state   = ST_READ;
                        end else begin
                            w_state = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sda_drive_low = r_sda_low;
    assign o_rx_data       = r_rx_data;
    assign o_rx_valid      = r_rx_valid;
    assign o_tx_load       = r_tx_load;
    assign o_busy          = r_busy;
    assign o_addressed     = r_addressed;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged open-drain master, a reference model of
// which transactions the target must ACK and what it must return, and a
// monitor that scores rx bytes against the expected queue.
module tb_i2c_target;

    localparam int Q = 10;
    localparam logic [6:0] MY_ADDR = 7'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic [7:0] tx_data;
    logic       sda_drive_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       busy;
    logic       addressed;

    wire w_sda_bus = m_sda & ~sda_drive_low;

    i2c_target #(.ADDRESS(MY_ADDR), .SYNC_STAGES(2)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_scl           (m_scl),
        .i_sda           (w_sda_bus),
        .o_sda_drive_low (sda_drive_low),
        .o_rx_data       (rx_data),
        .o_rx_valid      (rx_valid),
        .i_tx_data       (tx_data),
        .o_tx_load       (tx_load),
        .o_busy          (busy),
        .o_addressed     (addressed)
    );

    int          errors = 0;
    int          checks = 0;
    byte unsigned exp_rx[$];
    byte unsigned tx_q[$];
    byte unsigned dq[$];
    int          txload_seen = 0;
    int          txload_exp  = 0;
    bit          nodrive_en  = 1'b0;
    int          nodrive_viol = 0;
    int          high_drive_viol = 0;
    logic        prev_drive = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scores rx bytes, feeds tx bytes, watches SDA drive legality.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_data);
            end else begin
                check("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
            end
        end
        if (rst_n && tx_load) begin
            txload_seen++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        if (nodrive_en && sda_drive_low) nodrive_viol++;
        if (m_scl && sda_drive_low && !prev_drive) high_drive_viol++;
        prev_drive = sda_drive_low;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (!m_scl) begin
            m_sda = 1'b1; wq();
            m_scl = 1'b1; wq();
        end
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic clk_bit(input bit b, output bit s);
        m_sda = b;    wq();
        m_scl = 1'b1; wq();
        s = w_sda_bus; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input byte unsigned b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit nack, output byte unsigned b);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(nack, s);
    endtask

    // One transaction using the bytes in dq; the model decides ACK and data.
    task automatic xfer(input logic [6:0] addr, input bit rw, input bit do_stop);
        bit           ack;
        bit           match;
        byte unsigned r;
        match = (addr == MY_ADDR);
        if (rw && match) begin
            foreach (dq[i]) tx_q.push_back(dq[i]);
            txload_exp += dq.size();
        end
        i2c_start();
        check("start_busy", int'(busy), 1);
        check("start_addressed", int'(addressed), 0);
        nodrive_en = !match;
        write_byte({addr, rw}, ack);
        check("addr_ack", int'(ack), int'(match));
        check("addressed_after_addr", int'(addressed), int'(match));
        if (!rw) begin
            foreach (dq[i]) begin
                if (match) exp_rx.push_back(dq[i]);
                write_byte(dq[i], ack);
                check("data_ack", int'(ack), int'(match));
            end
        end else if (match) begin
            foreach (dq[i]) begin
                read_byte(i == dq.size() - 1, r);
                check("read_data", int'(r), int'(dq[i]));
            end
            check("read_released", int'(sda_drive_low), 0);
            check("read_busy_until_stop", int'(busy), 1);
        end
        nodrive_en = 1'b0;
        if (do_stop) begin
            i2c_stop();
            check("stop_busy", int'(busy), 0);
            check("stop_addressed", int'(addressed), 0);
        end
    endtask

    // Write byte whose SDA changes land in the same sampled cycle as SCL edges.
    task automatic simul_byte(input byte unsigned b, output bit ack);
        bit s;
        m_sda = b[7]; wq();
        m_scl = 1'b1; wq(); wq();
        m_scl = 1'b0; m_sda = b[6]; wq();
        m_scl = 1'b1; wq(); wq();
        m_scl = 1'b0; wq();
        m_scl = 1'b1; m_sda = b[5]; wq(); wq();
        m_scl = 1'b0; wq();
        for (int i = 4; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    initial begin
        bit         ack;
        logic [6:0] addr;
        bit         rw;
        int         n;

        rst_n = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs", int'({sda_drive_low, busy, addressed, rx_valid, tx_load, rx_data}), 0);
        rst_n = 1'b1;
        wq();

        // Write A5, 01 to our address.
        dq = {};
        dq.push_back(8'hA5); dq.push_back(8'h01);
        xfer(MY_ADDR, 1'b0, 1'b1);
        check("rx_data_last", int'(rx_data), 8'h01);

        // Wrong address: never driven, all NACK.
        dq = {};
        dq.push_back(8'h55);
        xfer(7'h3D, 1'b0, 1'b1);
        check("nack_no_drive", nodrive_viol, 0);

        // Read C3 (ACK) then 3C (NACK).
        dq = {};
        dq.push_back(8'hC3); dq.push_back(8'h3C);
        xfer(MY_ADDR, 1'b1, 1'b1);

        // Write 10, repeated START, read 9A with NACK.
        dq = {};
        dq.push_back(8'h10);
        xfer(MY_ADDR, 1'b0, 1'b0);
        check("addressed_before_rs", int'(addressed), 1);
        dq = {};
        dq.push_back(8'h9A);
        xfer(MY_ADDR, 1'b1, 1'b1);
        check("rx_data_after_rs", int'(rx_data), 8'h10);

        // Reset while driving a 0 bit in a read.
        tx_q.push_back(8'h00);
        txload_exp++;
        i2c_start();
        write_byte({MY_ADDR, 1'b1}, ack);
        check("rst_addr_ack", int'(ack), 1);
        check("rst_driving_zero", int'(sda_drive_low), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_read", int'({sda_drive_low, busy, addressed, rx_valid, tx_load, rx_data}), 0);
        wq();
        i2c_stop();
        dq = {};
        dq.push_back(8'(($urandom)));
        xfer(MY_ADDR, 1'b0, 1'b1);

        // SCL and SDA changing together: idle bus, then inside a write.
        m_scl = 1'b0; m_sda = 1'b0; wq();
        m_scl = 1'b1; m_sda = 1'b1; wq();
        check("simul_idle_busy", int'(busy), 0);
        i2c_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        check("simul_addr_ack", int'(ack), 1);
        exp_rx.push_back(8'hB5);
        simul_byte(8'hB5, ack);
        check("simul_data_ack", int'(ack), 1);
        check("simul_addressed", int'(addressed), 1);
        i2c_stop();

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            addr = ($urandom_range(0, 3) == 0) ? (MY_ADDR ^ 7'($urandom_range(1, 127))) : MY_ADDR;
            rw   = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, 3);
            dq = {};
            for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
            xfer(addr, rw, 1'b1);
        end

        wq();
        check("rx_all_delivered", exp_rx.size(), 0);
        check("txload_count", txload_seen, txload_exp);
        check("nodrive_total", nodrive_viol, 0);
        check("sda_change_scl_high", high_drive_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
